conv_channel_accumulator: RTL and testbench
===========================================

// Module: conv_channel_accumulator
// PURPOSE
//  Sits directly downstream of the stride-2 4x4 encoder conv. Sums that conv's per-input-channel
//  output frames (raster order, one pass per input channel) into one output-channel feature map.
//  On the last pass it saturates the sum to DATA_WIDTH, applies LeakyReLU and streams the result
//  to the next encoder layer. Holds one frame of partial sums in an internal accumulator RAM.
// PARAMETERS
//  OUT_WIDTH    16  side of the conv output frame; frame = OUT_WIDTH*OUT_WIDTH pixels
//  DATA_WIDTH   16  signed fixed-point width of data_in/data_out (same Q-format as the conv stage)
//  NUM_CH        3  input channels (passes) per output frame; >=1
//  ACC_WIDTH    20  signed accumulator width; must be >= DATA_WIDTH+clog2(NUM_CH)
//  LRELU_SHIFT   3  negative slope = 2^-LRELU_SHIFT (arithmetic right shift)
// PORTS
//  clk         in   1           clock, rising edge
//  rst_n       in   1           reset, asynchronous, active-low
//  clear       in   1           sync frame abort: zero counters, drop partial frame
//  valid_in    in   1           data_in is one conv output pixel
//  data_in     in   DATA_WIDTH  signed partial result for current channel/pixel
//  valid_out   out  1           data_out valid (1-cycle strobe per pixel)
//  data_out    out  DATA_WIDTH  signed activated output pixel
//  frame_done  out  1           1-cycle pulse coincident with last pixel's valid_out
//  busy        out  1           high while a frame is partly accumulated
// BEHAVIOUR
//  Reset: valid_out=0, data_out=0, frame_done=0, busy=0, pix_cnt=0, ch_cnt=0. RAM contents not reset
//   (ch 0 overwrites, never reads).
//  Counters: pix_cnt 0..OUT_WIDTH^2-1, ch_cnt 0..NUM_CH-1; advance only on valid_in.
//   pix_cnt wrap -> ch_cnt+1; wrap at ch_cnt==NUM_CH-1 -> ch_cnt=0 (new frame).
//  Per accepted pixel x=sext(data_in) to ACC_WIDTH:
//   ch_cnt==0 && NUM_CH>1    : acc[pix] <= x
//   0<ch_cnt<NUM_CH-1        : acc[pix] <= acc[pix]+x
//   ch_cnt==NUM_CH-1         : s = (NUM_CH==1 ? x : acc[pix]+x); no RAM write; output produced.
//  Output path, last channel only: sat = clamp(s, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1);
//   y = sat>=0 ? sat : sat>>>LRELU_SHIFT (floor). Registered: valid_out/data_out asserted the cycle
//   after valid_in (latency 1). data_out holds last value when valid_out=0.
//  frame_done=1 with valid_out of pixel OUT_WIDTH^2-1 of channel NUM_CH-1.
//  busy = (pix_cnt!=0)||(ch_cnt!=0).
//  Gaps: valid_in low for any number of cycles stalls everything; no output, no state change.
//  Back-to-back valid_in every cycle sustained; RAM read-modify-write of same address never occurs
//   in consecutive cycles (frame size >=4), so no bypass required.
//  clear: counters->0, valid_out/frame_done->0 next cycle; clear with valid_in same cycle: clear
//   wins, pixel dropped. Pending output from the previous cycle's valid_in is still emitted.
//  Reset mid-frame: all state as reset; upstream must restart at channel 0, pixel 0.
//  Bias: conv stage bias must be programmed on channel 0 pass only (0 on others); this block adds none.
//  No accumulator overflow handling beyond ACC_WIDTH sizing rule (parameter check by assertion).
// TESTING (OUT_WIDTH=4, NUM_CH=3, DATA_WIDTH=16, LRELU_SHIFT=3)
//  T1 3 passes x16 pixels of 0x0100, valid every cycle -> 16 outputs 0x0300, frame_done on 16th.
//  T2 3 passes all 0xFF00 (-256) -> outputs 0xFFA0 (-768>>>3=-96).
//  T3 3 passes 0x7000 -> sum 0x15000 saturates -> 0x7FFF; 3 passes 0x9000 -> -0x8000 -> 0xF000.
//  T4 pixel k channel c = k+16c, random valid_in gaps -> out k = 3k+48, order preserved, no extra.
//  T5 clear after ch1 pixel 5, then full clean frame of 0x0010 -> only 16 outputs 0x0030, busy drops.
//  T6 rst_n low mid-ch2, release, full frame 0x0001 -> outputs 0x0003; valid_out=0 during reset.

Source files
------------

// File: rtl/conv_channel_accumulator.sv
// Accumulates per-input-channel conv output frames into one output-channel map,
// then saturates, applies LeakyReLU and streams the result on the last pass.
module conv_channel_accumulator #(
  parameter int OUT_WIDTH   = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 3,
  parameter int ACC_WIDTH   = 20,
  parameter int LRELU_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int FRAME = OUT_WIDTH * OUT_WIDTH;
  localparam int PIX_W = $clog2(FRAME);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < DATA_WIDTH + $clog2(NUM_CH)) begin : g_acc_too_narrow
    $error("ACC_WIDTH too small for NUM_CH channel sum");
  end

  logic signed [ACC_WIDTH-1:0] acc_mem [FRAME];

  logic [PIX_W-1:0]            pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]             ch_cnt_q, ch_cnt_d;
  logic                        valid_out_q, valid_out_d;
  logic                        frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0]       data_out_q, data_out_d;

  logic                        accept;
  logic                        first_ch;
  logic                        last_ch;
  logic                        pix_last;
  logic                        wr_en;
  logic                        emit;
  logic signed [ACC_WIDTH-1:0] x;
  logic signed [ACC_WIDTH-1:0] rd;
  logic signed [ACC_WIDTH-1:0] s;
  logic signed [DATA_WIDTH-1:0] sat;
  logic signed [DATA_WIDTH-1:0] y;

  always_comb begin
    accept   = valid_in & ~clear;
    first_ch = (ch_cnt_q == '0);
    last_ch  = (ch_cnt_q == CH_LAST);
    pix_last = (pix_cnt_q == PIX_LAST);
    x        = ACC_WIDTH'($signed(data_in));
    rd       = acc_mem[pix_cnt_q];
    // Channel 0 overwrites stale RAM, so its read is ignored.
    s        = first_ch ? x : rd + x;
    wr_en    = accept & ~last_ch;
    emit     = accept & last_ch;
  end

  always_comb begin
    if (s > SAT_MAX) begin
      sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (s < SAT_MIN) begin
      sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat = s[DATA_WIDTH-1:0];
    end
    y = sat[DATA_WIDTH-1] ? (sat >>> LRELU_SHIFT) : sat;
  end

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    valid_out_d  = emit;
    frame_done_d = emit & pix_last;
    data_out_d   = emit ? y : data_out_q;
    if (clear) begin
      pix_cnt_d = '0;
      ch_cnt_d  = '0;
    end else if (valid_in) begin
      if (pix_last) begin
        pix_cnt_d = '0;
        ch_cnt_d  = last_ch ? '0 : ch_cnt_q + CH_W'(1);
      end else begin
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      data_out_q   <= data_out_d;
    end
  end

  // Partial-sum RAM carries no reset; channel 0 always rewrites it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      acc_mem[pix_cnt_q] <= s;
    end
  end

  assign valid_out  = valid_out_q;
  assign data_out   = data_out_q;
  assign frame_done = frame_done_q;
  assign busy       = (pix_cnt_q != '0) || (ch_cnt_q != '0);

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Directed bench for conv_channel_accumulator at OUT_WIDTH=4, NUM_CH=3.
module tb_conv_channel_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        valid_out;
  logic [15:0] data_out;
  logic        frame_done;
  logic        busy;

  int total = 0;
  int passed = 0;

  logic [15:0] oq[$];
  bit          fq[$];

  conv_channel_accumulator #(
    .OUT_WIDTH(4),
    .DATA_WIDTH(16),
    .NUM_CH(3),
    .ACC_WIDTH(20),
    .LRELU_SHIFT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .valid_in(valid_in),
    .data_in(data_in),
    .valid_out(valid_out),
    .data_out(data_out),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out) begin
      oq.push_back(data_out);
      fq.push_back(frame_done);
    end
  end

  task automatic px(input logic [15:0] d);
    valid_in = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_const(input logic [15:0] d);
    for (int i = 0; i < 48; i++) px(d);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (valid_out !== 1'b0)
      $display("FAIL reset_valid_out got %h want 0", valid_out);
    else passed++;
    total++;
    if (data_out !== 16'h0000)
      $display("FAIL reset_data_out got %h want 0000", data_out);
    else passed++;
    total++;
    if (frame_done !== 1'b0)
      $display("FAIL reset_frame_done got %h want 0", frame_done);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got %h want 0", busy);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_sum_pos();
    oq.delete(); fq.delete();
    frame_const(16'h0100);
    total++;
    if (busy !== 1'b0)
      $display("FAIL t1_busy_end got %h want 0", busy);
    else passed++;
    idle(2);
    total++;
    if (oq.size() != 16)
      $display("FAIL t1_count got %0d want 16", oq.size());
    else passed++;
    for (int i = 0; i < oq.size(); i++) begin
      total++;
      if (oq[i] !== 16'h0300 || fq[i] !== (i == 15))
        $display("FAIL t1_px%0d got %h/%0d want 0300/%0d",
                 i, oq[i], fq[i], i == 15);
      else passed++;
    end
    total++;
    if (valid_out !== 1'b0 || data_out !== 16'h0300)
      $display("FAIL t1_hold got %h/%h want 0/0300", valid_out, data_out);
    else passed++;
  endtask

  task automatic test_lrelu();
    oq.delete(); fq.delete();
    frame_const(16'hFF00);
    idle(2);
    total++;
    if (oq.size() != 16)
      $display("FAIL t2_count got %0d want 16", oq.size());
    else passed++;
    for (int i = 0; i < oq.size(); i++) begin
      total++;
      if (oq[i] !== 16'hFFA0)
        $display("FAIL t2_px%0d got %h want ffa0", i, oq[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back_sat();
    oq.delete(); fq.delete();
    frame_const(16'h7000);
    frame_const(16'h9000);
    idle(2);
    total++;
    if (oq.size() != 32)
      $display("FAIL t3_count got %0d want 32", oq.size());
    else passed++;
    for (int i = 0; i < oq.size(); i++) begin
      total++;
      if (oq[i] !== (i < 16 ? 16'h7FFF : 16'hF000) ||
          fq[i] !== (i == 15 || i == 31))
        $display("FAIL t3_px%0d got %h/%0d want %h/%0d", i, oq[i], fq[i],
                 i < 16 ? 16'h7FFF : 16'hF000, i == 15 || i == 31);
      else passed++;
    end
  endtask

  task automatic test_gaps();
    oq.delete(); fq.delete();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 16; k++) begin
        px(16'(k + 16 * c));
        idle($urandom_range(0, 3));
      end
    end
    idle(3);
    total++;
    if (oq.size() != 16)
      $display("FAIL t4_count got %0d want 16", oq.size());
    else passed++;
    for (int i = 0; i < oq.size(); i++) begin
      total++;
      if (oq[i] !== 16'(3 * i + 48) || fq[i] !== (i == 15))
        $display("FAIL t4_px%0d got %h/%0d want %h/%0d", i, oq[i], fq[i],
                 16'(3 * i + 48), i == 15);
      else passed++;
    end
  endtask

  task automatic test_clear();
    oq.delete(); fq.delete();
    for (int i = 0; i < 22; i++) px(16'h0055);
    total++;
    if (busy !== 1'b1)
      $display("FAIL t5_busy_mid got %h want 1", busy);
    else passed++;
    clear    = 1'b1;
    valid_in = 1'b1;
    data_in  = 16'h0077;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    valid_in = 1'b0;
    total++;
    if (busy !== 1'b0)
      $display("FAIL t5_busy_clear got %h want 0", busy);
    else passed++;
    frame_const(16'h0010);
    idle(2);
    total++;
    if (oq.size() != 16)
      $display("FAIL t5_count got %0d want 16", oq.size());
    else passed++;
    for (int i = 0; i < oq.size(); i++) begin
      total++;
      if (oq[i] !== 16'h0030 || fq[i] !== (i == 15))
        $display("FAIL t5_px%0d got %h/%0d want 0030/%0d",
                 i, oq[i], fq[i], i == 15);
      else passed++;
    end
    total++;
    if (busy !== 1'b0)
      $display("FAIL t5_busy_end got %h want 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 37; i++) px(16'h0001);
    idle(2);
    oq.delete(); fq.delete();
    rst_n    = 1'b0;
    valid_in = 1'b1;
    data_in  = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (valid_out !== 1'b0 || busy !== 1'b0)
        $display("FAIL t6_in_reset%0d got %h/%h want 0/0",
                 i, valid_out, busy);
      else passed++;
    end
    valid_in = 1'b0;
    rst_n    = 1'b1;
    idle(1);
    frame_const(16'h0001);
    idle(2);
    total++;
    if (oq.size() != 16)
      $display("FAIL t6_count got %0d want 16", oq.size());
    else passed++;
    for (int i = 0; i < oq.size(); i++) begin
      total++;
      if (oq[i] !== 16'h0003 || fq[i] !== (i == 15))
        $display("FAIL t6_px%0d got %h/%0d want 0003/%0d",
                 i, oq[i], fq[i], i == 15);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_sum_pos();
    test_lrelu();
    test_back_to_back_sat();
    test_gaps();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
